// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_mmio responder.
//   - reg_off_t   : register offsets within the 4-word window
//   - ST_*        : STATUS register bit positions
//   - tx_state_t  : transmitter FSM states
//   - rx_state_t  : receiver FSM states
//   - eff_div()   : divider clamp (values below 2 behave as 2)
package uart_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DIV    = 2'd2
  } reg_off_t;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_TX_BUSY      = 2;
  localparam int unsigned ST_RX_VALID     = 3;
  localparam int unsigned ST_RX_OVERRUN   = 4;
  localparam int unsigned ST_TX_OVF       = 5;
  localparam int unsigned ST_RX_FRAME_ERR = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU single-cycle word bus as seen by the UART responder.
//   bus_addr   : word address (CPU -> UART)
//   bus_data_w : write data    (CPU -> UART)
//   bus_mask_w : byte enables, nonzero = write (CPU -> UART)
//   bus_data_r : combinational read data (UART -> CPU)
//   hit        : address falls in the UART window (UART -> CPU)
interface uart_mmio_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        hit;

  modport master (output bus_addr, bus_data_w, bus_mask_w, input bus_data_r, hit);
  modport slave  (input bus_addr, bus_data_w, bus_mask_w, output bus_data_r, hit);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO, DEPTH entries (power of two, 2..256).
//   clock, reset_n : clock and asynchronous active-low reset
//   push, wdata    : enqueue (ignored when full)
//   pop, rdata     : dequeue; rdata shows the head entry combinationally
//   full, empty    : occupancy flags
//   count          : number of stored entries
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART on the CPU word bus.
//   Window of 4 words at BASE: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
//   Ports:
//     clock, reset_n : clock, asynchronous active-low reset
//     bus            : uart_mmio_if.slave (addr/data/mask in, data_r/hit out)
//     tx             : 8N1 serial output, idle high
//     rx             : serial input (asynchronous), used only with UART_RX_EN
//   Build option: define UART_RX_EN to include the receiver; otherwise rx is
//   ignored and RX status/data read as zero.
module uart_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h4000_0000,
  parameter int unsigned CLOCK_DIV  = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  uart_mmio_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic hit_w, wr_en, wr_data, wr_status, wr_div;
  assign hit_w     = (bus.bus_addr[31:2] == BASE[31:2]);
  assign bus.hit   = hit_w;
  assign wr_en     = hit_w && (bus.bus_mask_w != 4'b0000);
  assign wr_data   = wr_en && (bus.bus_addr[1:0] == REG_DATA);
  assign wr_status = wr_en && (bus.bus_addr[1:0] == REG_STATUS) && bus.bus_mask_w[0];
  assign wr_div    = wr_en && (bus.bus_addr[1:0] == REG_DIV);

  // ---------------- DIV register ----------------
  logic [15:0] div_q, div_d, bit_len;
  assign bit_len = eff_div(div_q) - 16'd1;

  always_comb begin
    div_d = div_q;
    if (wr_div && bus.bus_mask_w[0]) div_d[7:0]  = bus.bus_data_w[7:0];
    if (wr_div && bus.bus_mask_w[1]) div_d[15:8] = bus.bus_data_w[15:8];
  end

  // ---------------- TX FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [8:0]    count_ext;
  logic          tx_ovf_q, tx_ovf_d;

  assign fifo_push = wr_data && bus.bus_mask_w[0];
  assign count_ext = 9'(fifo_count);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (bus.bus_data_w[7:0]),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (wr_status && bus.bus_data_w[ST_TX_OVF]) tx_ovf_d = 1'b0;
    // full is sampled before this cycle's pop, so a push racing a pop still drops
    if (fifo_push && fifo_full) tx_ovf_d = 1'b1;
  end

  // ---------------- TX serializer ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;

  assign tx = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = bit_len;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = bit_len;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = bit_len;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!fifo_empty) begin
            // chain straight into the next start bit
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_cnt_d   = bit_len;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_d       = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= 16'(CLOCK_DIV);
      tx_ovf_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      div_q      <= div_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- RX ----------------
  logic       rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_byte;
  logic       unused_ok;

`ifdef UART_RX_EN
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic        rx_frame_err_q, rx_frame_err_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        valid_after_pop;

  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_byte      = rx_byte_q;
  assign unused_ok    = ^{bus.bus_data_w[31:16], count_ext[8]};

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_byte_d      = rx_byte_q;
    // a same-cycle pop frees the holding register before a completing frame lands
    valid_after_pop = rx_valid_q && !(wr_status && bus.bus_data_w[ST_RX_VALID]);
    rx_valid_d     = valid_after_pop;
    rx_overrun_d   = rx_overrun_q && !(wr_status && bus.bus_data_w[ST_RX_OVERRUN]);
    rx_frame_err_d = rx_frame_err_q && !(wr_status && bus.bus_data_w[ST_RX_FRAME_ERR]);
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = (eff_div(div_q) >> 1) - 16'd1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = bit_len;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = bit_len;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (!rx_s2_q) begin
            rx_frame_err_d = 1'b1;
          end else if (valid_after_pop) begin
            rx_overrun_d = 1'b1;
          end else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_s1_q        <= rx;
      rx_s2_q        <= rx_s1_q;
      rx_prev_q      <= rx_s2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end
`else
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = '0;
  assign unused_ok    = ^{bus.bus_data_w[31:16], count_ext[8], rx};
`endif

  // ---------------- read mux ----------------
  always_comb begin
    bus.bus_data_r = '0;
    if (hit_w) begin
      case (bus.bus_addr[1:0])
        REG_DATA:   bus.bus_data_r = {23'b0, rx_valid, rx_byte};
        REG_STATUS: begin
          bus.bus_data_r[ST_TX_FULL]      = fifo_full;
          bus.bus_data_r[ST_TX_EMPTY]     = fifo_empty;
          bus.bus_data_r[ST_TX_BUSY]      = (tx_state_q != TX_IDLE);
          bus.bus_data_r[ST_RX_VALID]     = rx_valid;
          bus.bus_data_r[ST_RX_OVERRUN]   = rx_overrun;
          bus.bus_data_r[ST_TX_OVF]       = tx_ovf_q;
          bus.bus_data_r[ST_RX_FRAME_ERR] = rx_frame_err;
          bus.bus_data_r[15:8]            = count_ext[7:0];
        end
        REG_DIV:    bus.bus_data_r = {16'b0, div_q};
        default:    bus.bus_data_r = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;
  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'd1;
  localparam logic [31:0] A_DIV    = BASE + 32'd2;
  localparam logic [31:0] A_RSV    = BASE + 32'd3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic tx;
  int   checks  = 0;
  int   errors  = 0;

  uart_mmio_if bus_if();

  uart_mmio #(
    .BASE       (BASE),
    .CLOCK_DIV  (868),
    .FIFO_DEPTH (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if),
    .tx      (tx),
    .rx      (rx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.bus_addr = a;
    #1;
    d = bus_if.bus_data_r;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  // Called at a negedge: commits on the next posedge, returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_if.bus_addr   = a;
    bus_if.bus_data_w = d;
    bus_if.bus_mask_w = m;
    @(negedge clock);
    bus_if.bus_mask_w = 4'b0000;
    bus_if.bus_data_w = '0;
  endtask

  // k counts clocks after the write edge; bit index is (k-1)/div.
  task automatic check_tx(input logic [19:0] bits, input int n, input int div, input int k0);
    logic [31:0] st;
    for (int k = k0; k <= n * div; k++) begin
      chk($sformatf("tx_k%0d", k), {31'b0, tx}, {31'b0, bits[(k-1)/div]});
      if (k == n * div) begin
        rd(A_STATUS, st);
        chk("tx_busy_last_clk", {31'b0, st[2]}, 32'd1);
      end
      @(negedge clock);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
    rx = 1'b0;
    repeat (div) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clock);
    end
    rx = stopb;
    repeat (div) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    logic [31:0] d;
    bus_if.bus_addr   = '0;
    bus_if.bus_data_w = '0;
    bus_if.bus_mask_w = 4'b0000;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // reset state and decode
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk_rd("rst_status", A_STATUS, 32'h0000_0002);
    chk_rd("rst_div", A_DIV, 32'd868);
    chk_rd("rst_data", A_DATA, 32'h0);
    chk_rd("rsv_read", A_RSV, 32'h0);
    bus_if.bus_addr = A_DATA; #1;
    chk("hit_in", {31'b0, bus_if.hit}, 32'd1);
    chk_rd("miss_read", BASE + 32'd6, 32'h0);
    chk("hit_out", {31'b0, bus_if.hit}, 32'd0);
    wr(BASE + 32'd6, 32'h0000_0005, 4'hF);
    chk_rd("miss_write_div", A_DIV, 32'd868);
    wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
    chk_rd("rsv_write_read", A_RSV, 32'h0);
    chk_rd("rsv_write_status", A_STATUS, 32'h0000_0002);

    // DIV write: upper bits ignored
    wr(A_DIV, 32'hFFFF_0004, 4'b0011);
    chk_rd("div4", A_DIV, 32'h0000_0004);

    // single frame 0x55 at DIV=4
    wr(A_DATA, 32'h55, 4'b0001);
    chk("f55_k0_tx", {31'b0, tx}, 32'd1);
    chk_rd("f55_k0_status", A_STATUS, 32'h0000_0100);
    @(negedge clock);
    check_tx({10'b0, 1'b1, 8'h55, 1'b0}, 10, 4, 1);
    chk("f55_idle_tx", {31'b0, tx}, 32'd1);
    chk_rd("f55_idle_status", A_STATUS, 32'h0000_0002);

    // DIV below 2 behaves as 2
    wr(A_DIV, 32'h0, 4'b0011);
    chk_rd("div0_read", A_DIV, 32'h0);
    wr(A_DATA, 32'h0F, 4'b0001);
    @(negedge clock);
    check_tx({10'b0, 1'b1, 8'h0F, 1'b0}, 10, 2, 1);
    chk_rd("div0_idle_status", A_STATUS, 32'h0000_0002);
    wr(A_DIV, 32'h4, 4'b0001);

    // back-to-back frames; second push coincides with the first pop
    wr(A_DATA, 32'hA5, 4'b0001);
    wr(A_DATA, 32'h3C, 4'b0001);
    chk_rd("b2b_status", A_STATUS, 32'h0000_0104);
    check_tx({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, 4, 1);
    chk("b2b_idle_tx", {31'b0, tx}, 32'd1);
    chk_rd("b2b_idle_status", A_STATUS, 32'h0000_0002);

    // overflow while shifter is busy with a long frame of zeros
    wr(A_DIV, 32'h0000_03E8, 4'b0011);
    wr(A_DATA, 32'h00, 4'b0001);
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'h10 + i, 4'b0001);
    chk_rd("ovf_status", A_STATUS, 32'h0000_1025);
    chk("ovf_tx_low", {31'b0, tx}, 32'd0);
    wr(A_STATUS, 32'h20, 4'b0001);
    chk_rd("ovf_cleared", A_STATUS, 32'h0000_1005);
    wr(A_DATA, 32'h77, 4'b0000);
    chk_rd("mask0_nowrite", A_STATUS, 32'h0000_1005);
    for (int i = 0; i < 5; i++) begin
      rd(A_DATA, d);
      rd(A_STATUS, d);
      rd(A_DIV, d);
      @(negedge clock);
    end
    chk_rd("reads_status", A_STATUS, 32'h0000_1005);
    chk_rd("reads_div", A_DIV, 32'h0000_03E8);

    // reset mid-frame
    chk("pre_rst_tx", {31'b0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk_rd("mid_rst_status", A_STATUS, 32'h0000_0002);
    chk_rd("mid_rst_div", A_DIV, 32'd868);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_rd("post_rst_status", A_STATUS, 32'h0000_0002);

    wr(A_DIV, 32'h4, 4'b0001);
`ifdef UART_RX_EN
    send_rx(8'hC3, 1'b1, 4);
    chk_rd("rx_c3_data", A_DATA, 32'h0000_01C3);
    chk_rd("rx_c3_status", A_STATUS, 32'h0000_000A);
    wr(A_STATUS, 32'h08, 4'b0001);
    chk_rd("rx_pop_data", A_DATA, 32'h0000_00C3);
    send_rx(8'h81, 1'b1, 4);
    chk_rd("rx_81_data", A_DATA, 32'h0000_0181);
    send_rx(8'h7E, 1'b1, 4);
    chk_rd("rx_ovr_data", A_DATA, 32'h0000_0181);
    chk_rd("rx_ovr_status", A_STATUS, 32'h0000_001A);
    wr(A_STATUS, 32'h10, 4'b0001);
    chk_rd("rx_ovr_clr", A_STATUS, 32'h0000_000A);
    wr(A_STATUS, 32'h08, 4'b0001);
    chk_rd("rx_pop2", A_STATUS, 32'h0000_0002);
    send_rx(8'h99, 1'b0, 4);
    chk_rd("rx_ferr_status", A_STATUS, 32'h0000_0042);
    chk_rd("rx_ferr_data", A_DATA, 32'h0000_0081);
    wr(A_STATUS, 32'h40, 4'b0001);
    chk_rd("rx_ferr_clr", A_STATUS, 32'h0000_0002);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (12) @(negedge clock);
    chk_rd("rx_glitch_status", A_STATUS, 32'h0000_0002);
    chk_rd("rx_glitch_data", A_DATA, 32'h0000_0081);
`else
    send_rx(8'hC3, 1'b1, 4);
    chk_rd("norx_data", A_DATA, 32'h0);
    chk_rd("norx_status", A_STATUS, 32'h0000_0002);
    wr(A_STATUS, 32'h58, 4'b0001);
    chk_rd("norx_w1c", A_STATUS, 32'h0000_0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
